// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx
// Device-side (keyboard) PS/2 transmitter. Scancode bytes are queued in a
// small FIFO and sent as 11-bit frames (start, 8 data LSB first, odd
// parity, stop). The block generates the PS/2 clock itself.
//
// Handshake: tx_wr is a single-cycle strobe. A byte is accepted on a rising
// clk edge where tx_wr=1 and tx_full=0. A strobe while tx_full=1 drops the
// byte and raises overflow for exactly one cycle after that edge. There is
// no back-pressure beyond tx_full, so the writer must check it first.
//
// Transmission is device-to-host only. The block does not support host
// commands or clock inhibit. The FSM state is held in the enum 'state' so
// checkers can bind to it.

module ps2_kbd_tx #(
   parameter int CLK_DIV    = 2000,  // clk cycles per ps2Clk half-period, >= 2
   parameter int FIFO_AW    = 3,     // FIFO depth = 2**FIFO_AW bytes
   parameter int GAP_HALVES = 2      // idle half-periods between frames, >= 1
) (
   input  logic       clk,
   input  logic       N_RESET,
   input  logic [7:0] tx_data,
   input  logic       tx_wr,
   output logic       tx_full,
   output logic       tx_busy,
   output logic       overflow,
   output logic       ps2Clk,
   output logic       ps2Data
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int DIV_W = $clog2(GAP_HALVES * CLK_DIV + 1);

   localparam logic [DIV_W-1:0]   DIV_ONE   = DIV_W'(1);
   localparam logic [DIV_W-1:0]   HALF_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0]   GAP_LAST  = DIV_W'(GAP_HALVES * CLK_DIV - 1);
   localparam logic [FIFO_AW:0]   FULL_CNT  = (FIFO_AW + 1)'(DEPTH);
   localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
   localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
   localparam logic [3:0]         LAST_BIT  = 4'd10;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,   // link idle, waiting for a queued byte
      ST_LOAD = 3'd1,   // pop the byte and build the frame
      ST_HIGH = 3'd2,   // ps2Clk high, data bit presented
      ST_LOW  = 3'd3,   // ps2Clk low, host samples the data bit
      ST_GAP  = 3'd4    // inter-frame idle time with the clock high
   } state_t;

   state_t            state;
   logic [DIV_W-1:0]  div_cnt;
   logic [3:0]        bit_cnt;
   logic [10:0]       shreg;

   // FIFO storage and bookkeeping
   logic [7:0]         fifo_mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [FIFO_AW:0]   fifo_cnt;
   logic               fifo_push;
   logic               fifo_pop;
   logic [7:0]         pop_byte;

   // tx_full is derived from the pre-edge count. A write in the same cycle
   // as a pop on a full FIFO is still dropped.
   assign tx_full   = (fifo_cnt == FULL_CNT);
   assign tx_busy   = (state != ST_IDLE) || (fifo_cnt != '0);
   assign fifo_push = tx_wr & ~tx_full;
   assign fifo_pop  = (state == ST_LOAD);
   assign pop_byte  = fifo_mem[rd_ptr];

   // FIFO data array: written on an accepted strobe. No reset is needed
   // because the read side only looks at entries counted in fifo_cnt.
   always_ff @(posedge clk) begin
      if (fifo_push) begin
         fifo_mem[wr_ptr] <= tx_data;
      end
   end

   // FIFO pointers and occupancy. The pointers wrap naturally at the depth.
   always_ff @(posedge clk) begin
      if (!N_RESET) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (fifo_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (fifo_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({fifo_push, fifo_pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
            2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Overflow pulse: a strobe that arrived while the FIFO was full.
   always_ff @(posedge clk) begin
      if (!N_RESET) begin
         overflow <= 1'b0;
      end else begin
         overflow <= tx_wr & tx_full;
      end
   end

   // Frame sequencer. ps2Clk and ps2Data are registered here.
   // Data only moves while ps2Clk is high and steady:
   //  - The start bit is driven on entry to the first HIGH phase. The clock
   //    is already high coming out of IDLE.
   //  - Later bits are driven in the first cycle after ps2Clk has risen.
   //    Data therefore never changes in the same cycle as a clock edge.
   always_ff @(posedge clk) begin
      if (!N_RESET) begin
         state   <= ST_IDLE;
         div_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '1;
         ps2Clk  <= 1'b1;
         ps2Data <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               ps2Clk  <= 1'b1;
               ps2Data <= 1'b1;
               div_cnt <= '0;
               if (fifo_cnt != '0) begin
                  state <= ST_LOAD;
               end
            end

            ST_LOAD: begin
               // Frame layout, bit 0 first: start, d[0..7], odd parity, stop.
               shreg   <= {1'b1, ~^pop_byte, pop_byte, 1'b0};
               bit_cnt <= '0;
               div_cnt <= '0;
               ps2Data <= 1'b0;          // start bit, same value as new shreg[0]
               state   <= ST_HIGH;
            end

            ST_HIGH: begin
               ps2Data <= shreg[0];
               if (div_cnt == HALF_LAST) begin
                  div_cnt <= '0;
                  ps2Clk  <= 1'b0;
                  state   <= ST_LOW;
               end else begin
                  div_cnt <= div_cnt + DIV_ONE;
               end
            end

            ST_LOW: begin
               if (div_cnt == HALF_LAST) begin
                  div_cnt <= '0;
                  ps2Clk  <= 1'b1;
                  if (bit_cnt == LAST_BIT) begin
                     // The stop bit is already 1, so ps2Data does not move.
                     ps2Data <= 1'b1;
                     state   <= ST_GAP;
                  end else begin
                     shreg   <= {1'b1, shreg[10:1]};
                     bit_cnt <= bit_cnt + 4'd1;
                     state   <= ST_HIGH;
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_ONE;
               end
            end

            ST_GAP: begin
               ps2Clk  <= 1'b1;
               ps2Data <= 1'b1;
               if (div_cnt == GAP_LAST) begin
                  div_cnt <= '0;
                  state   <= ST_IDLE;
               end else begin
                  div_cnt <= div_cnt + DIV_ONE;
               end
            end

            default: begin
               state   <= ST_IDLE;
               div_cnt <= '0;
               ps2Clk  <= 1'b1;
               ps2Data <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// tb_ps2_kbd_tx
// Directed bench for ps2_kbd_tx. A PS/2 host model samples ps2Data on each
// ps2Clk fall and assembles 11-bit frames. Every assembled frame is popped
// against the expected queue, which the driver fills when it queues a byte.
// An invariant monitor watches clock/data edge alignment and the low-phase
// width.

module tb_ps2_kbd_tx;

   localparam int CLK_DIV    = 4;
   localparam int FIFO_AW    = 2;
   localparam int GAP_HALVES = 2;

   logic       clk = 1'b0;
   logic       N_RESET;
   logic [7:0] tx_data;
   logic       tx_wr;
   logic       tx_full;
   logic       tx_busy;
   logic       overflow;
   logic       ps2Clk;
   logic       ps2Data;

   ps2_kbd_tx #(
      .CLK_DIV    (CLK_DIV),
      .FIFO_AW    (FIFO_AW),
      .GAP_HALVES (GAP_HALVES)
   ) dut (
      .clk      (clk),
      .N_RESET  (N_RESET),
      .tx_data  (tx_data),
      .tx_wr    (tx_wr),
      .tx_full  (tx_full),
      .tx_busy  (tx_busy),
      .overflow (overflow),
      .ps2Clk   (ps2Clk),
      .ps2Data  (ps2Data)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard state
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [10:0] exp_q[$];
   int          start_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic fail(input string name, input string what);
      n_checks++;
      $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
   endtask

   function automatic logic [10:0] frame_of(input logic [7:0] d, input logic par);
      return {1'b1, par, d, 1'b0};
   endfunction

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Queue one byte. par is the hand-computed odd-parity bit. Only bytes the
   // host should see are pushed to the expected queue.
   task automatic send(input logic [7:0] d, input logic par, input bit expect_tx);
      if (expect_tx) exp_q.push_back(frame_of(d, par));
      tx_data = d;
      tx_wr   = 1'b1;
      tick();
      tx_wr   = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget, output int when);
      when = -1;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (tx_busy === 1'b0 && exp_q.size() == 0) begin
            when = cyc;
            return;
         end
      end
      fail(name, "timed out waiting for transmitter idle");
   endtask

   // PS/2 host model and invariant monitor
   logic        prev_clk;
   logic        prev_data;
   int          bit_idx = 0;
   int          low_len = 0;
   logic [10:0] rx;
   logic [10:0] exp_f;

   always @(negedge clk) begin
      if (N_RESET !== 1'b1) begin
         bit_idx   = 0;
         low_len   = 0;
         prev_clk  = ps2Clk;
         prev_data = ps2Data;
      end else begin
         if (ps2Clk !== prev_clk) begin
            check("data_moved_on_clk_edge", 32'(ps2Data !== prev_data), 32'd0);
            if (ps2Clk === 1'b0) begin
               rx[bit_idx] = ps2Data;
               bit_idx++;
               low_len = 1;
               if (bit_idx == 11) begin
                  bit_idx = 0;
                  if (exp_q.size() == 0) begin
                     fail("frame", $sformatf("unexpected frame 0x%03h", rx));
                  end else begin
                     exp_f = exp_q.pop_front();
                     check("frame", 32'(rx), 32'(exp_f));
                  end
               end
            end else begin
               check("low_phase_len", 32'(low_len), 32'(CLK_DIV));
            end
         end else if (ps2Clk === 1'b0) begin
            low_len++;
         end
         if (bit_idx == 0 && ps2Clk === 1'b1 && prev_data === 1'b1 && ps2Data === 1'b0)
            start_q.push_back(cyc);
         prev_clk  = ps2Clk;
         prev_data = ps2Data;
      end
   end

   // Watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

   // Directed stimulus
   initial begin
      int c0;
      int when;
      int found;
      int bad;

      N_RESET = 1'b0;
      tx_wr   = 1'b0;
      tx_data = 8'h00;

      // Power-on reset
      repeat (3) tick();
      @(negedge clk);
      check("rst_ps2Clk",   32'(ps2Clk),   32'd1);
      check("rst_ps2Data",  32'(ps2Data),  32'd1);
      check("rst_tx_full",  32'(tx_full),  32'd0);
      check("rst_tx_busy",  32'(tx_busy),  32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      tick();
      N_RESET = 1'b1;
      repeat (3) tick();

      // Single byte 0x1C: start bit 2 cycles after the write, first fall at 6
      send(8'h1C, 1'b0, 1'b1);
      c0 = cyc;
      found = 0;
      for (int n = 0; n < 20 && found == 0; n++) begin
         @(negedge clk);
         if (ps2Data === 1'b0) found = 1;
      end
      if (found == 1) check("start_latency", 32'(cyc - c0), 32'd2);
      else fail("start_latency", "start bit never appeared");
      found = 0;
      for (int n = 0; n < 20 && found == 0; n++) begin
         @(negedge clk);
         if (ps2Clk === 1'b0) found = 1;
      end
      if (found == 1) check("first_fall", 32'(cyc - c0), 32'd6);
      else fail("first_fall", "ps2Clk never fell");
      wait_idle("single_idle", 2000, when);

      // Parity corner cases
      send(8'h00, 1'b1, 1'b1);
      send(8'hFF, 1'b1, 1'b1);
      send(8'h01, 1'b0, 1'b1);
      wait_idle("parity_idle", 2000, when);

      // Back-to-back frames: starts 98 cycles apart, busy until last gap ends
      start_q.delete();
      send(8'hE0, 1'b0, 1'b1);
      send(8'hF0, 1'b1, 1'b1);
      send(8'h1C, 1'b0, 1'b1);
      wait_idle("b2b_idle", 2000, when);
      check("b2b_start_count", 32'(start_q.size()), 32'd3);
      if (start_q.size() == 3) begin
         check("b2b_gap_1_2", 32'(start_q[1] - start_q[0]), 32'd98);
         check("b2b_gap_2_3", 32'(start_q[2] - start_q[1]), 32'd98);
         check("b2b_busy_end", 32'(when - start_q[2]), 32'd96);
      end

      // Overflow: five writes all fit (one popped at LOAD), sixth is dropped
      send(8'h11, 1'b1, 1'b1);
      send(8'h23, 1'b0, 1'b1);
      send(8'h35, 1'b1, 1'b1);
      send(8'h47, 1'b1, 1'b1);
      send(8'h58, 1'b0, 1'b1);
      check("full_after_5", 32'(tx_full), 32'd1);
      check("no_ovf_after_5", 32'(overflow), 32'd0);
      send(8'h66, 1'b0, 1'b0);
      check("ovf_pulse", 32'(overflow), 32'd1);
      tick();
      check("ovf_cleared", 32'(overflow), 32'd0);
      wait_idle("ovf_idle", 3000, when);
      repeat (20) @(negedge clk);

      // Reset mid-frame with another byte still queued
      send(8'hAA, 1'b0, 1'b0);
      send(8'hBB, 1'b1, 1'b0);
      repeat (30) tick();
      N_RESET = 1'b0;
      tick();
      @(negedge clk);
      check("midrst_ps2Clk",  32'(ps2Clk),  32'd1);
      check("midrst_ps2Data", 32'(ps2Data), 32'd1);
      check("midrst_tx_busy", 32'(tx_busy), 32'd0);
      check("midrst_tx_full", 32'(tx_full), 32'd0);
      tick();
      tick();
      N_RESET = 1'b1;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx_busy !== 1'b0 || ps2Clk !== 1'b1 || ps2Data !== 1'b1) bad++;
      end
      check("post_reset_quiet", 32'(bad), 32'd0);

      // Link recovers after the aborted frame
      send(8'h5A, 1'b1, 1'b1);
      wait_idle("recover_idle", 2000, when);
      repeat (10) @(negedge clk);

      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
